signed_to_20b_signed: RTL and testbench

- Converts a two's-complement value of parameterised width LENGTH into a 20-bit two's-complement value.
- Sits between narrow signed producers (e.g. 10-bit coordinate or velocity fields) and the 20-bit signed datapath.
- Provides a combinational result and a registered result with valid and overflow flags.

---
 rtl/signed_to_20b_signed.sv | 74 +++++++
 tb/tb_signed_to_20b_signed.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/signed_to_20b_signed.sv
`default_nettype none
// ============================================================================
// Module      : signed_to_20b_signed
// Description : Resizes a LENGTH-bit two's-complement value to 20 bits
//               (sign-extend, pass, saturate or truncate), plus a registered
//               copy with valid and overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_to_20b_signed #(
    parameter int LENGTH   = 10,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LENGTH-1:0] in,
    input  logic              in_valid,
    output logic [19:0]       out,
    output logic [19:0]       out_q,
    output logic              out_valid,
    output logic              ovf
);

    localparam int c_OUT_W = 20;

    logic [c_OUT_W-1:0] w_res;
    logic               w_ovf;
    logic [c_OUT_W-1:0] r_out_q;
    logic               r_out_valid;
    logic               r_ovf;

    generate
        if (LENGTH < c_OUT_W) begin : g_extend
            assign w_res = {{(c_OUT_W - LENGTH){in[LENGTH-1]}}, in};
            assign w_ovf = 1'b0;
        end else if (LENGTH == c_OUT_W) begin : g_pass
            assign w_res = in;
            assign w_ovf = 1'b0;
        end else begin : g_narrow
            // Bits 19 and above must all match the sign for the value to fit.
            logic [LENGTH-c_OUT_W:0] w_upper;
            logic                    w_fits;
            assign w_upper = in[LENGTH-1:c_OUT_W-1];
            assign w_fits  = (&w_upper) | ~(|w_upper);
            assign w_ovf   = ~w_fits;
            if (SATURATE) begin : g_sat
                assign w_res = w_fits          ? in[c_OUT_W-1:0] :
                               in[LENGTH-1]    ? 20'h80000       : 20'h7FFFF;
            end else begin : g_trunc
                assign w_res = in[c_OUT_W-1:0];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (in_valid) begin
            r_out_q     <= w_res;
            r_out_valid <= 1'b1;
            r_ovf       <= w_ovf;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = w_res;
    assign out_q     = r_out_q;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_signed_to_20b_signed.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_to_20b_signed
// Description : Directed bench over four configurations of signed_to_20b_signed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_to_20b_signed;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [9:0]  in10;
    logic [23:0] in24;
    logic [0:0]  in1;

    logic [19:0] out10, outs, outt, out1;
    logic [19:0] q10, qs, qt, q1;
    logic        v10, vs, vt, v1;
    logic        o10, os, ot, o1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        int          unit;
        logic [19:0] q;
        logic        v;
        logic        o;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    signed_to_20b_signed #(.LENGTH(10), .SATURATE(1'b1)) u10 (
        .clk(clk), .rst_n(rst_n), .in(in10), .in_valid(in_valid),
        .out(out10), .out_q(q10), .out_valid(v10), .ovf(o10));
    signed_to_20b_signed #(.LENGTH(24), .SATURATE(1'b1)) u24s (
        .clk(clk), .rst_n(rst_n), .in(in24), .in_valid(in_valid),
        .out(outs), .out_q(qs), .out_valid(vs), .ovf(os));
    signed_to_20b_signed #(.LENGTH(24), .SATURATE(1'b0)) u24t (
        .clk(clk), .rst_n(rst_n), .in(in24), .in_valid(in_valid),
        .out(outt), .out_q(qt), .out_valid(vt), .ovf(ot));
    signed_to_20b_signed #(.LENGTH(1), .SATURATE(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .in_valid(in_valid),
        .out(out1), .out_q(q1), .out_valid(v1), .ovf(o1));

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int unit, input logic [19:0] q,
                        input logic v, input logic o);
        exp_t e;
        e.tag = tag; e.unit = unit; e.q = q; e.v = v; e.o = o;
        sb.push_back(e);
    endtask

    task automatic push_all_reset(input string tag);
        for (int u = 0; u < 4; u++) push(tag, u, 20'h00000, 1'b0, 1'b0);
    endtask

    // Advance one edge, then check every registered expectation queued for it.
    task automatic tick();
        exp_t e;
        logic [19:0] q;
        logic v, o;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.unit)
                0:       begin q = q10; v = v10; o = o10; end
                1:       begin q = qs;  v = vs;  o = os;  end
                2:       begin q = qt;  v = vt;  o = ot;  end
                default: begin q = q1;  v = v1;  o = o1;  end
            endcase
            chk({e.tag, ".out_q"},     q,          e.q);
            chk({e.tag, ".out_valid"}, {19'd0, v}, {19'd0, e.v});
            chk({e.tag, ".ovf"},       {19'd0, o}, {19'd0, e.o});
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in10 = '0; in24 = '0; in1 = '0;
        push_all_reset("reset");
        tick();

        // First load: -420
        rst_n = 1'b1; in_valid = 1'b1; in10 = 10'b1001011100;
        #1 chk("comb_m420", out10, 20'hFFE5C);
        push("load_m420", 0, 20'hFFE5C, 1'b1, 1'b0);
        tick();

        in_valid = 1'b0;
        in10 = 10'h1FF; #1 chk("comb_maxpos", out10, 20'h001FF);
        in10 = 10'h200; #1 chk("comb_maxneg", out10, 20'hFFE00);
        in10 = 10'h000; #1 chk("comb_zero",   out10, 20'h00000);
        in10 = 10'h3FF; #1 chk("comb_m1",     out10, 20'hFFFFF);

        // Load then hold
        in_valid = 1'b1; in10 = 10'h123;
        push("load_123", 0, 20'h00123, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0; in10 = 10'h3FF;
        #1 chk("comb_hold_m1", out10, 20'hFFFFF);
        push("hold_123", 0, 20'h00123, 1'b0, 1'b0);
        tick();

        // 24-bit narrowing, saturating (unit 1) and truncating (unit 2)
        in_valid = 1'b1; in24 = 24'h100000;
        #1 chk("comb_sat_2p20", outs, 20'h7FFFF);
        chk("comb_trn_2p20", outt, 20'h00000);
        push("sat_2p20", 1, 20'h7FFFF, 1'b1, 1'b1);
        push("trn_2p20", 2, 20'h00000, 1'b1, 1'b1);
        tick();
        in24 = 24'hF00000;
        push("sat_F00000", 1, 20'h80000, 1'b1, 1'b1);
        push("trn_F00000", 2, 20'h00000, 1'b1, 1'b1);
        tick();
        in24 = 24'hFFFFFF;
        push("sat_m1", 1, 20'hFFFFF, 1'b1, 1'b0);
        push("trn_m1", 2, 20'hFFFFF, 1'b1, 1'b0);
        tick();
        in24 = 24'h07FFFF;
        push("sat_edge_fit", 1, 20'h7FFFF, 1'b1, 1'b0);
        push("trn_edge_fit", 2, 20'h7FFFF, 1'b1, 1'b0);
        tick();
        in24 = 24'h080000;
        push("sat_edge_ovf", 1, 20'h7FFFF, 1'b1, 1'b1);
        push("trn_edge_ovf", 2, 20'h80000, 1'b1, 1'b1);
        tick();
        in24 = 24'hF80000;
        push("sat_neg_fit", 1, 20'h80000, 1'b1, 1'b0);
        tick();

        // LENGTH=1
        in1 = 1'b1;
        #1 chk("comb_l1_one", out1, 20'hFFFFF);
        push("l1_one", 3, 20'hFFFFF, 1'b1, 1'b0);
        tick();
        in1 = 1'b0;
        #1 chk("comb_l1_zero", out1, 20'h00000);

        // Mid-stream reset with in_valid high
        in10 = 10'h055;
        push("pre_reset", 0, 20'h00055, 1'b1, 1'b0);
        tick();
        rst_n = 1'b0; in10 = 10'h2AA;
        #1 chk("comb_in_reset", out10, 20'hFFEAA);
        push_all_reset("mid_reset");
        tick();
        rst_n = 1'b1; in10 = 10'h0AA;
        push("post_reset", 0, 20'h000AA, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        push("post_idle", 0, 20'h000AA, 1'b0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
